dbus_arbiter: RTL and testbench

//   Shares one data_bus slave port (req/gnt/rvalid handshake) between NUM_MASTERS requesters
//   (LSU, debug module, DMA). Round-robin arbitration; the winner is held until the slave grants.

---
 rtl/dbus_arbiter_if.sv | 17 +
 rtl/dbus_arbiter.sv | 119 +++++++++++
 tb/tb_dbus_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dbus_arbiter_if.sv
// Data-bus request/grant/response bundle. LANES requesters share one response data path;
// the arbiter uses a LANES=NUM_MASTERS instance upstream and a LANES=1 instance toward the slave.
interface dbus_arbiter_if #(
  parameter int unsigned LANES = 1
);
  logic [LANES-1:0]    req;
  logic [LANES-1:0]    we;
  logic [4*LANES-1:0]  be;
  logic [32*LANES-1:0] addr;
  logic [32*LANES-1:0] wdata;
  logic [LANES-1:0]    gnt;
  logic [LANES-1:0]    rvalid;
  logic [31:0]         rdata;

  modport master (output req, we, be, addr, wdata, input  gnt, rvalid, rdata);
  modport slave  (input  req, we, be, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/dbus_arbiter.sv
// Round-robin arbiter sharing one data-bus slave between NUM_MASTERS requesters; granted IDs
// are queued in order so each response is routed back to the master that issued it.
module dbus_arbiter #(
  parameter int unsigned NUM_MASTERS     = 2,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic           clk,
  input  logic           rst,
  dbus_arbiter_if.slave  m,
  dbus_arbiter_if.master s,
  output logic           err_resp
);
  localparam int unsigned IDW = $clog2(NUM_MASTERS);
  localparam int unsigned PW  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CW  = $clog2(MAX_OUTSTANDING + 1);

  typedef logic [IDW-1:0] id_t;
  typedef enum logic {ARB, HOLD} state_t;

  state_t        state, state_nxt;
  id_t           rr_ptr, sel, winner, cur;
  logic          any_req, active, grant, pop;
  logic          fifo_full, fifo_empty;
  id_t           fifo_mem [MAX_OUTSTANDING];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;

  assign fifo_full  = (count == CW'(MAX_OUTSTANDING));
  assign fifo_empty = (count == '0);

  // First requester at or after rr_ptr, searched in circular order.
  always_comb begin : pick
    int unsigned k;
    id_t         kk;
    winner  = '0;
    any_req = 1'b0;
    k       = 0;
    kk      = '0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      k = 32'(rr_ptr) + i;
      if (k >= NUM_MASTERS) k = k - NUM_MASTERS;
      kk = id_t'(k);
      if (m.req[kk] && !any_req) begin
        winner  = kk;
        any_req = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ARB:     if (!fifo_full && any_req && !s.gnt[0]) state_nxt = HOLD;
      HOLD:    if (s.gnt[0]) state_nxt = ARB;
      default: state_nxt = ARB;
    endcase
  end

  // NOTE: every output gets a default before any branch so no path leaves a value held,
  // which would otherwise infer a latch.
  always_comb begin
    cur      = (state == HOLD) ? sel : winner;
    active   = !rst && ((state == HOLD) || (!fifo_full && any_req));
    grant    = active && s.gnt[0];
    pop      = !rst && s.rvalid[0] && !fifo_empty;
    s.req    = active;
    s.we     = '0;
    s.be     = '0;
    s.addr   = '0;
    s.wdata  = '0;
    m.gnt    = '0;
    m.rvalid = '0;
    m.rdata  = '0;
    if (active) begin
      s.we    = m.we[cur];
      s.be    = m.be[4*cur +: 4];
      s.addr  = m.addr[32*cur +: 32];
      s.wdata = m.wdata[32*cur +: 32];
    end
    if (grant) m.gnt[cur] = 1'b1;
    if (pop) begin
      m.rvalid[fifo_mem[rd_ptr]] = 1'b1;
      m.rdata                    = s.rdata;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples the
  // pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ARB;
      sel      <= '0;
      rr_ptr   <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      err_resp <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == ARB) sel <= winner;
      if (grant) begin
        rr_ptr <= (cur == id_t'(NUM_MASTERS - 1)) ? '0 : cur + 1'b1;
        wr_ptr <= (wr_ptr == PW'(MAX_OUTSTANDING - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= (rd_ptr == PW'(MAX_OUTSTANDING - 1)) ? '0 : rd_ptr + 1'b1;
      case ({grant, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (s.rvalid[0] && fifo_empty) err_resp <= 1'b1;
    end
  end

  // NOTE: ID storage has no reset; entries are only read while count says they are valid.
  always_ff @(posedge clk) begin
    if (grant) fifo_mem[wr_ptr] <= cur;
  end
endmodule

// File: tb/tb_dbus_arbiter.sv
// Randomised and directed bench for dbus_arbiter: a queue-based reference model predicts every
// cycle, and a monitor process compares the DUT against the predictions.
module tb_dbus_arbiter;
  localparam int N  = 3;
  localparam int MO = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic err_resp;

  always #5 clk = ~clk;

  dbus_arbiter_if #(.LANES(N)) bm ();
  dbus_arbiter_if #(.LANES(1)) bs ();

  dbus_arbiter #(.NUM_MASTERS(N), .MAX_OUTSTANDING(MO)) dut (
    .clk(clk), .rst(rst), .m(bm), .s(bs), .err_resp(err_resp)
  );

  typedef struct {
    int           cyc;
    logic         sreq;
    logic [31:0]  saddr;
    logic [N-1:0] gnt;
    logic [N-1:0] rvalid;
    logic         err;
  } cyc_t;

  typedef struct {
    int          id;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } gnt_t;

  typedef struct {
    int          id;
    logic [31:0] data;
  } rsp_t;

  cyc_t cyc_q[$];
  gnt_t gnt_q[$];
  rsp_t rsp_q[$];

  // Master-side stimulus and slave-side stimulus
  logic        req_a [N];
  logic        we_a  [N];
  logic [3:0]  be_a  [N];
  logic [31:0] addr_a[N];
  logic [31:0] wdata_a[N];
  logic        rst_v, s_gnt_v, s_rvalid_v;
  logic [31:0] s_rdata_v;

  // Reference model: rotating priority, optional locked master, ordered list of outstanding IDs
  int rr_m;
  int lock_m;
  int idq[$];
  bit err_m;
  int cyc;

  int total;
  int bad;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  task automatic raise(input int i);
    req_a[i]   = 1'b1;
    we_a[i]    = 1'($urandom % 2);
    be_a[i]    = 4'($urandom);
    addr_a[i]  = $urandom & 32'hFFFF_FFFC;
    wdata_a[i] = $urandom;
  endtask

  // One clock cycle: apply inputs after the edge, predict this cycle, advance the model.
  task automatic step();
    cyc_t c;
    gnt_t g;
    rsp_t r;
    int   cur;
    bit   act;
    bit   full;
    @(posedge clk);
    #1;
    cyc++;
    rst = rst_v;
    for (int i = 0; i < N; i++) begin
      bm.req[i]            = req_a[i];
      bm.we[i]             = we_a[i];
      bm.be[4*i +: 4]      = be_a[i];
      bm.addr[32*i +: 32]  = addr_a[i];
      bm.wdata[32*i +: 32] = wdata_a[i];
    end
    bs.gnt[0]    = s_gnt_v;
    bs.rvalid[0] = s_rvalid_v;
    bs.rdata     = s_rdata_v;

    c.cyc = cyc; c.sreq = 1'b0; c.saddr = '0; c.gnt = '0; c.rvalid = '0; c.err = 1'b0;
    if (rst_v) begin
      rr_m   = 0;
      lock_m = -1;
      idq.delete();
      err_m  = 1'b0;
    end else begin
      c.err = err_m;
      full  = (idq.size() == MO);
      act   = 1'b0;
      cur   = 0;
      if (lock_m >= 0) begin
        act = 1'b1;
        cur = lock_m;
      end else if (!full) begin
        for (int i = 0; i < N; i++) begin
          int k;
          k = (rr_m + i) % N;
          if (!act && req_a[k]) begin
            act = 1'b1;
            cur = k;
          end
        end
      end
      if (act) begin
        c.sreq  = 1'b1;
        c.saddr = addr_a[cur];
      end
      if (s_rvalid_v) begin
        if (idq.size() > 0) begin
          c.rvalid[idq[0]] = 1'b1;
          r.id   = idq[0];
          r.data = s_rdata_v;
          rsp_q.push_back(r);
          void'(idq.pop_front());
        end else begin
          err_m = 1'b1;
        end
      end
      if (act && s_gnt_v) begin
        c.gnt[cur] = 1'b1;
        g.id = cur; g.we = we_a[cur]; g.be = be_a[cur]; g.addr = addr_a[cur]; g.wdata = wdata_a[cur];
        gnt_q.push_back(g);
        idq.push_back(cur);
        rr_m       = (cur + 1) % N;
        lock_m     = -1;
        req_a[cur] = 1'b0;
      end else if (act) begin
        lock_m = cur;
      end
    end
    cyc_q.push_back(c);
  endtask

  task automatic do_reset();
    rst_v = 1'b1; s_gnt_v = 1'b0; s_rvalid_v = 1'b0;
    step();
    rst_v = 1'b0;
    for (int i = 0; i < N; i++) req_a[i] = 1'b0;
    step();
  endtask

  // Grant every pending request and answer every outstanding ID.
  task automatic flush();
    for (int t = 0; t < 32; t++) begin
      bit any;
      any = 1'b0;
      for (int i = 0; i < N; i++) any |= req_a[i];
      if (!any && idq.size() == 0 && lock_m < 0) break;
      s_gnt_v    = 1'b1;
      s_rvalid_v = (idq.size() > 0);
      s_rdata_v  = $urandom;
      step();
    end
    s_gnt_v = 1'b0; s_rvalid_v = 1'b0;
  endtask

  // Monitor: control outputs every cycle; payloads whenever the DUT presents a grant or response
  initial begin
    cyc_t c;
    gnt_t g;
    rsp_t r;
    forever begin
      @(negedge clk);
      if (cyc_q.size() > 0) begin
        c = cyc_q.pop_front();
        check("s_req", 64'(bs.req), 64'(c.sreq));
        check("s_addr", 64'(bs.addr), 64'(c.saddr));
        check("m_gnt", 64'(bm.gnt), 64'(c.gnt));
        check("m_rvalid", 64'(bm.rvalid), 64'(c.rvalid));
        check("err_resp", 64'(err_resp), 64'(c.err));
        if (bm.gnt != '0) begin
          if (gnt_q.size() == 0) fail_now("unexpected_grant");
          else begin
            g = gnt_q.pop_front();
            check("gnt_id", 64'(bm.gnt), 64'(1) << g.id);
            check("s_we", 64'(bs.we), 64'(g.we));
            check("s_be", 64'(bs.be), 64'(g.be));
            check("gnt_addr", 64'(bs.addr), 64'(g.addr));
            check("s_wdata", 64'(bs.wdata), 64'(g.wdata));
          end
        end
        if (bm.rvalid != '0) begin
          if (rsp_q.size() == 0) fail_now("unexpected_response");
          else begin
            r = rsp_q.pop_front();
            check("rsp_id", 64'(bm.rvalid), 64'(1) << r.id);
            check("m_rdata", 64'(bm.rdata), 64'(r.data));
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0; bad = 0; cyc = 0;
    rr_m = 0; lock_m = -1; err_m = 1'b0;
    for (int i = 0; i < N; i++) begin
      req_a[i] = 1'b0; we_a[i] = 1'b0; be_a[i] = '0; addr_a[i] = '0; wdata_a[i] = '0;
    end
    s_gnt_v = 1'b0; s_rvalid_v = 1'b0; s_rdata_v = '0;
    do_reset();
    step();

    // Single master, same-cycle grant, response one cycle later
    raise(0); s_gnt_v = 1'b1;
    step();
    s_gnt_v = 1'b0; s_rvalid_v = 1'b1; s_rdata_v = 32'hDEAD_BEEF;
    step();
    s_rvalid_v = 1'b0;
    step();

    // Two masters requesting continuously: alternating grants, responses one cycle later
    for (int k = 0; k < 8; k++) begin
      if (!req_a[0]) raise(0);
      if (!req_a[1]) raise(1);
      s_gnt_v = 1'b1; s_rvalid_v = (idq.size() > 0); s_rdata_v = $urandom;
      step();
    end
    flush();

    // Slave stalls: master 0 held while master 1 arrives
    raise(0); s_gnt_v = 1'b0;
    step();
    raise(1);
    step();
    step();
    s_gnt_v = 1'b1;
    step();
    step();
    flush();

    // Full ID FIFO blocks the third request until the cycle after a slot frees
    raise(0); raise(1); s_gnt_v = 1'b1;
    step();
    step();
    raise(2);
    step();
    s_rvalid_v = 1'b1; s_rdata_v = $urandom;
    step();
    s_rvalid_v = 1'b0;
    step();
    flush();

    // Response with nothing outstanding sets the sticky error
    s_rvalid_v = 1'b1; s_rdata_v = $urandom;
    step();
    s_rvalid_v = 1'b0;
    step();
    step();

    // Reset while holding with one ID queued
    do_reset();
    raise(0); s_gnt_v = 1'b1;
    step();
    raise(1); s_gnt_v = 1'b0;
    step();
    rst_v = 1'b1;
    step();
    rst_v = 1'b0;
    for (int i = 0; i < N; i++) req_a[i] = 1'b0;
    s_rvalid_v = 1'b1; s_rdata_v = $urandom;
    step();
    s_rvalid_v = 1'b0;
    raise(0); raise(2); s_gnt_v = 1'b1;
    step();
    flush();

    // Random traffic with legal slave responses
    do_reset();
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < N; i++)
        if (!req_a[i] && ($urandom % 3 == 0)) raise(i);
      s_gnt_v    = ($urandom % 4 != 0);
      s_rvalid_v = (idq.size() > 0) && ($urandom % 2 == 1);
      s_rdata_v  = $urandom;
      step();
    end
    flush();
    step();

    @(negedge clk);
    #1;
    check("grants_left", 64'(gnt_q.size()), 64'(0));
    check("responses_left", 64'(rsp_q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
